shift_accumulator: RTL and testbench
====================================

Name: shift_accumulator

Overview:
Receiving end of the global IO partial-sum path. Takes one sign-extended combined partial sum per input-activation bit-slice, MSB-first. Performs bit-serial shift-and-add over IN_BITS beats to form the full-precision MAC result. Presents the result to the downstream output buffer through a valid/ready handshake.

Parameters:
PSUM_WIDTH, 27, width of the incoming combined partial sum (two's complement)
ACC_WIDTH, 36, accumulator and result width (two's complement)
IN_BITS, 8, number of activation bit-slices (beats) per accumulation; legal range 2..16

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a new accumulation; accepted only in IDLE
signed_in  input  1  activation is signed; sampled with start and held for the whole run
psum_in  input  PSUM_WIDTH  combined partial sum for the current bit-slice
psum_valid  input  1  psum_in valid this cycle
psum_ready  output  1  high only in ACCUM; a beat transfers when psum_valid && psum_ready
acc_out  output  ACC_WIDTH  accumulated result; stable while acc_valid is high
acc_valid  output  1  result available
acc_ready  input  1  downstream accepts result
busy  output  1  high in ACCUM or DONE
ovf  output  1  sticky overflow/saturation flag for the current run (see Optional Feature)

Behaviour:
- Reset: state=IDLE, acc=0, beat counter=0, acc_out=0, acc_valid=0, psum_ready=0, busy=0, ovf=0. Reset takes effect at any time, including mid-run and in DONE. Any partial result is discarded.
- FSM IDLE -> ACCUM on start. Clears acc to 0 and the counter to 0, latches signed_in, and clears ovf.
- In IDLE, a psum_valid asserted in the same cycle as start is ignored. The first beat is accepted no earlier than the next cycle.
- ACCUM: on each transferred beat, sext(psum_in) is sign-extended to ACC_WIDTH.
  - Beat 0 (activation MSB): acc <= (acc<<1) - sext(psum_in) if the latched signed_in=1. Otherwise acc <= (acc<<1) + sext(psum_in).
  - Beats 1..IN_BITS-1: acc <= (acc<<1) + sext(psum_in).
  - Cycles with psum_valid=0 hold acc and the counter (stalls allowed, unbounded).
- The transfer of beat IN_BITS-1 moves ACCUM -> DONE. On the next cycle acc_valid=1 and acc_out=final acc. Latency from last beat to acc_valid is 1 cycle.
- DONE: acc_out and acc_valid hold until acc_valid && acc_ready. Then the FSM returns to IDLE on the next cycle with acc_valid=0.
- acc_out keeps its last value in IDLE (not cleared).
- start is ignored in ACCUM and DONE. A start on the same cycle as the DONE handshake is also ignored; start must be reasserted in IDLE.
- psum_valid outside ACCUM is ignored, and psum_ready=0 there.
- Arithmetic wraps modulo 2^ACC_WIDTH unless ACC_SAT_EN is defined.

Optional Feature:
Macro: ACC_SAT_EN.
- Defined: each update is computed at ACC_WIDTH+2 bits and clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Any clamp sets ovf, which stays high until the next accepted start or rst.
  - Once saturated, subsequent shifts continue from the clamped value.
- Undefined: plain wrap-around arithmetic, and ovf is tied to 0.

Test Plan:
1. Defaults, signed_in=0, 8 beats of psum_in=1, acc_ready=1 -> acc_out=255 (0x0FF), acc_valid high exactly 1 cycle after the last beat.
2. signed_in=1, 8 beats of psum_in=1 -> acc_out=-1 (all ones). signed_in=1, beat0=1 and the other beats 0 -> acc_out=-128.
3. signed_in=0, 8 beats of psum_in=27'h7FFFFFF (-1), with psum_valid deasserted 2 cycles between beats 3 and 4 -> acc_out=-255, and psum_ready stays high during the stall.
4. Complete a run with acc_ready=0 for 3 cycles, pulse start during DONE -> acc_out/acc_valid held for 4 cycles, return to IDLE after the handshake, start ignored, busy=0 afterwards.
5. rst pulsed after 5 of 8 beats -> next cycle state IDLE, acc_valid=0, busy=0. A fresh run of 8 beats of psum_in=2 then gives acc_out=510.
6. ACC_SAT_EN defined, ACC_WIDTH=30, signed_in=0, 8 beats of psum_in=2^26-1 -> acc_out=0x1FFFFFFF and ovf=1. Without the macro, the same stimulus gives the wrapped value (2^26-1)*255 mod 2^30 and ovf=0.

Source files
------------

// File: rtl/shift_accumulator.sv
// ---------------------------------------------------------------------------
// shift_accumulator
//
// Receiving end of the global IO partial-sum path. One sign-extended
// combined partial sum arrives per input-activation bit-slice, MSB first.
// Each beat does acc = 2*acc +/- psum, so after IN_BITS beats acc holds the
// full-precision MAC result. The result goes to the output buffer through a
// valid/ready handshake.
//
// Build option:
//   ACC_SAT_EN  - when defined, every update saturates to the signed
//                 ACC_WIDTH range and sets the sticky ovf flag. When
//                 undefined, arithmetic wraps and ovf stays 0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   begin an accumulation (honoured only in IDLE)
//   signed_in  in   activation is signed (captured with start)
//   psum_in    in   combined partial sum for the current bit-slice
//   psum_valid in   psum_in valid
//   psum_ready out  high in ACCUM; a beat moves on valid && ready
//   acc_out    out  accumulated result, held while acc_valid
//   acc_valid  out  result available
//   acc_ready  in   downstream takes the result
//   busy       out  high in ACCUM or DONE
//   ovf        out  sticky saturation flag for the current run
// ---------------------------------------------------------------------------
module shift_accumulator #(
    parameter int PSUM_WIDTH = 27,
    parameter int ACC_WIDTH  = 36,
    parameter int IN_BITS    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_in,
    input  logic [PSUM_WIDTH-1:0] psum_in,
    input  logic                  psum_valid,
    output logic                  psum_ready,
    output logic [ACC_WIDTH-1:0]  acc_out,
    output logic                  acc_valid,
    input  logic                  acc_ready,
    output logic                  busy,
    output logic                  ovf
);

    localparam int CNT_W = $clog2(IN_BITS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t                 state_q,     state_d;
    logic [ACC_WIDTH-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic                   signed_q,    signed_d;
    logic [ACC_WIDTH-1:0]   acc_out_q,   acc_out_d;
    logic                   acc_valid_q, acc_valid_d;
    logic                   ovf_q,       ovf_d;

    // The MSB slice of a signed activation carries weight -2^(IN_BITS-1),
    // so its partial sum is subtracted instead of added.
    logic subtract;
    assign subtract = signed_q && (cnt_q == '0);

    logic [ACC_WIDTH-1:0] acc_next;
    logic                 clamp;

`ifdef ACC_SAT_EN
    // Two guard bits: 2*acc +/- psum cannot exceed ACC_WIDTH+2 bits, so the
    // comparison against the clamp bounds is exact.
    localparam int WW = ACC_WIDTH + 2;
    localparam logic signed [WW-1:0] SAT_MAX = {3'b000, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [WW-1:0] SAT_MIN = {3'b111, {(ACC_WIDTH-1){1'b0}}};

    logic signed [WW-1:0] wide_acc;
    logic signed [WW-1:0] wide_psum;
    logic signed [WW-1:0] wide_sum;

    always_comb begin
        wide_acc  = {{2{acc_q[ACC_WIDTH-1]}}, acc_q};
        wide_psum = {{(WW-PSUM_WIDTH){psum_in[PSUM_WIDTH-1]}}, psum_in};
        wide_sum  = subtract ? (wide_acc <<< 1) - wide_psum
                             : (wide_acc <<< 1) + wide_psum;
        if (wide_sum > SAT_MAX) begin
            acc_next = SAT_MAX[ACC_WIDTH-1:0];
            clamp    = 1'b1;
        end else if (wide_sum < SAT_MIN) begin
            acc_next = SAT_MIN[ACC_WIDTH-1:0];
            clamp    = 1'b1;
        end else begin
            acc_next = wide_sum[ACC_WIDTH-1:0];
            clamp    = 1'b0;
        end
    end
`else
    logic [ACC_WIDTH-1:0] psum_ext;
    logic [ACC_WIDTH-1:0] acc_shift;

    always_comb begin
        psum_ext  = {{(ACC_WIDTH-PSUM_WIDTH){psum_in[PSUM_WIDTH-1]}}, psum_in};
        acc_shift = {acc_q[ACC_WIDTH-2:0], 1'b0};
        acc_next  = subtract ? acc_shift - psum_ext : acc_shift + psum_ext;
        clamp     = 1'b0;
    end
`endif

    always_comb begin
        // NOTE: every signal gets a hold default first, so no path through
        // the case can leave one unassigned and infer a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        signed_d    = signed_q;
        acc_out_d   = acc_out_q;
        acc_valid_d = acc_valid_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                // psum_valid is ignored here, even alongside start.
                if (start) begin
                    state_d  = S_ACCUM;
                    acc_d    = '0;
                    cnt_d    = '0;
                    signed_d = signed_in;
                    ovf_d    = 1'b0;
                end
            end
            S_ACCUM: begin
                if (psum_valid) begin
                    acc_d = acc_next;
                    ovf_d = ovf_q | clamp;
                    if (cnt_q == LAST_BEAT) begin
                        state_d     = S_DONE;
                        cnt_d       = '0;
                        acc_out_d   = acc_next;
                        acc_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                // start is ignored here, including on the handshake cycle.
                if (acc_ready) begin
                    state_d     = S_IDLE;
                    acc_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            signed_q    <= 1'b0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            signed_q    <= signed_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign psum_ready = (state_q == S_ACCUM);
    assign busy       = (state_q != S_IDLE);
    assign acc_out    = acc_out_q;
    assign acc_valid  = acc_valid_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_shift_accumulator.sv
// ---------------------------------------------------------------------------
// Testbench for shift_accumulator. Two instances run in lockstep on shared
// stimulus: dut_a with default widths, dut_b with ACC_WIDTH=30 for the
// overflow case. Expected results for the ACC_SAT_EN build follow the macro.
// ---------------------------------------------------------------------------
module tb_shift_accumulator;

    localparam int PW = 27;
    localparam int AW = 36;
    localparam int BW = 30;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          signed_in;
    logic [PW-1:0] psum_in;
    logic          psum_valid;
    logic          acc_ready;

    logic          psum_ready_a, acc_valid_a, busy_a, ovf_a;
    logic [AW-1:0] acc_out_a;
    logic          psum_ready_b, acc_valid_b, busy_b, ovf_b;
    logic [BW-1:0] acc_out_b;

    always #5 clk = ~clk;

    shift_accumulator #(.PSUM_WIDTH(PW), .ACC_WIDTH(AW), .IN_BITS(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .signed_in(signed_in),
        .psum_in(psum_in), .psum_valid(psum_valid), .psum_ready(psum_ready_a),
        .acc_out(acc_out_a), .acc_valid(acc_valid_a), .acc_ready(acc_ready),
        .busy(busy_a), .ovf(ovf_a)
    );

    shift_accumulator #(.PSUM_WIDTH(PW), .ACC_WIDTH(BW), .IN_BITS(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .signed_in(signed_in),
        .psum_in(psum_in), .psum_valid(psum_valid), .psum_ready(psum_ready_b),
        .acc_out(acc_out_b), .acc_valid(acc_valid_b), .acc_ready(acc_ready),
        .busy(busy_b), .ovf(ovf_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    typedef struct {
        string         name;
        logic          sgn;
        logic [PW-1:0] first;     // beat 0 value
        logic [PW-1:0] rest;      // beats 1..7 value
        int            stall_at;  // beat preceded by a stall, -1 for none
        int            stall_len;
        int            hold;      // cycles acc_ready stays low in DONE
        logic [AW-1:0] exp_a;
        logic [BW-1:0] exp_b;
        logic          exp_ovf_b;
    } vec_t;

    // (2^26-1)*255 = 0x3FBFFFF01; mod 2^30 = 0x3BFFFF01.
    localparam logic [PW-1:0] BIG = 27'h3FFFFFF;
`ifdef ACC_SAT_EN
    localparam logic [BW-1:0] BIG_EXP_B = 30'h1FFFFFFF;
    localparam logic          BIG_OVF_B = 1'b1;
`else
    localparam logic [BW-1:0] BIG_EXP_B = 30'h3BFFFF01;
    localparam logic          BIG_OVF_B = 1'b0;
`endif

    // One accumulation run starting and ending at a negedge.
    task automatic run(input vec_t v);
        logic [PW-1:0] val;
        acc_ready  = (v.hold == 0);
        start      = 1'b1;
        signed_in  = v.sgn;
        psum_valid = 1'b1;          // must be ignored alongside start
        psum_in    = 27'd5;
        @(negedge clk);
        start = 1'b0;
        check({v.name, " ready_in_accum"}, 64'(psum_ready_a), 64'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == v.stall_at) begin
                psum_valid = 1'b0;
                for (int s = 0; s < v.stall_len; s++) begin
                    @(negedge clk);
                    check({v.name, " ready_during_stall"}, 64'(psum_ready_a), 64'd1);
                end
            end
            val        = (i == 0) ? v.first : v.rest;
            psum_in    = val;
            psum_valid = 1'b1;
            if (i == 7)
                check({v.name, " valid_before_last"}, 64'(acc_valid_a), 64'd0);
            @(negedge clk);
        end
        psum_valid = 1'b0;
        check({v.name, " valid_after_last"}, 64'(acc_valid_a), 64'd1);
        check({v.name, " acc_out_a"}, 64'(acc_out_a), 64'(v.exp_a));
        check({v.name, " acc_out_b"}, 64'(acc_out_b), 64'(v.exp_b));
        check({v.name, " ovf_b"}, 64'(ovf_b), 64'(v.exp_ovf_b));
        check({v.name, " ovf_a"}, 64'(ovf_a), 64'd0);
        for (int k = 0; k < v.hold; k++) begin
            start = (k == 1);        // start in DONE must be ignored
            @(negedge clk);
            check({v.name, " valid_held"}, 64'(acc_valid_a), 64'd1);
            check({v.name, " out_held"}, 64'(acc_out_a), 64'(v.exp_a));
        end
        if (v.hold > 0) begin
            acc_ready = 1'b1;
            start     = 1'b1;        // same cycle as handshake: ignored
        end
        @(negedge clk);
        start = 1'b0;
        check({v.name, " valid_dropped"}, 64'(acc_valid_a), 64'd0);
        check({v.name, " busy_idle"}, 64'(busy_a), 64'd0);
        check({v.name, " out_kept"}, 64'(acc_out_a), 64'(v.exp_a));
        @(negedge clk);
        check({v.name, " still_idle"}, 64'(busy_a), 64'd0);
        check({v.name, " ready_idle"}, 64'(psum_ready_a), 64'd0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"unsigned_ones", 1'b0, 27'd1, 27'd1, -1, 0, 0,
                    36'd255, 30'd255, 1'b0};
        vecs[1] = '{"signed_ones", 1'b1, 27'd1, 27'd1, -1, 0, 0,
                    {AW{1'b1}}, {BW{1'b1}}, 1'b0};
        vecs[2] = '{"signed_msb_only", 1'b1, 27'd1, 27'd0, -1, 0, 0,
                    -36'sd128, -30'sd128, 1'b0};
        vecs[3] = '{"unsigned_msb_only", 1'b0, 27'd1, 27'd0, -1, 0, 0,
                    36'd128, 30'd128, 1'b0};
        vecs[4] = '{"unsigned_neg_stall", 1'b0, 27'h7FFFFFF, 27'h7FFFFFF, 4, 2, 0,
                    -36'sd255, -30'sd255, 1'b0};
        vecs[5] = '{"signed_neg_hold", 1'b1, 27'h7FFFFFF, 27'h7FFFFFF, -1, 0, 3,
                    36'd1, 30'd1, 1'b0};
        vecs[6] = '{"big_overflow", 1'b0, BIG, BIG, -1, 0, 0,
                    36'h3FBFFFF01, BIG_EXP_B, BIG_OVF_B};

        rst = 1'b1; start = 1'b0; signed_in = 1'b0; psum_in = '0;
        psum_valid = 1'b0; acc_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset acc_out", 64'(acc_out_a), 64'd0);
        check("reset acc_valid", 64'(acc_valid_a), 64'd0);
        check("reset busy", 64'(busy_a), 64'd0);
        check("reset psum_ready", 64'(psum_ready_a), 64'd0);
        check("reset ovf", 64'(ovf_a), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run(vecs[i]);

        // Reset after 5 of 8 beats discards the run.
        start = 1'b1; signed_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        psum_in = 27'd3; psum_valid = 1'b1;
        repeat (5) @(negedge clk);
        psum_valid = 1'b0;
        check("mid busy", 64'(busy_a), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst acc_valid", 64'(acc_valid_a), 64'd0);
        check("midrst busy", 64'(busy_a), 64'd0);
        check("midrst psum_ready", 64'(psum_ready_a), 64'd0);
        check("midrst acc_out", 64'(acc_out_a), 64'd0);
        run('{"after_reset_twos", 1'b0, 27'd2, 27'd2, -1, 0, 0,
              36'd510, 30'd510, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
